// File: rtl/ariane_pkg.sv
// Shared core types: widths, functional-unit encoding and the reorder-buffer entry layout.
package ariane_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned VLEN          = 64;
  localparam int unsigned ROB_DEPTH     = 8;
  localparam int unsigned TRANS_ID_BITS = $clog2(ROB_DEPTH);

  typedef enum logic [3:0] {
    FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT, FU_CSR, FU_FPU
  } fu_t;

  typedef struct packed {
    logic            allocated;
    logic            written;
    logic [VLEN-1:0] pc;
    logic [4:0]      rd;
    fu_t             fu;
    logic [XLEN-1:0] result;
    logic            ex_valid;
    logic [XLEN-1:0] ex_cause;
  } rob_entry_t;

endpackage

// File: rtl/commit_rob.sv
// Circular reorder buffer: in-order allocation, out-of-order writeback, in-order multi-port commit.
module commit_rob
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = ROB_DEPTH,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_WB_PORTS     = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          flush_i,
  input  logic                                          issue_valid_i,
  output logic                                          issue_ready_o,
  input  logic [VLEN-1:0]                               issue_pc_i,
  input  logic [4:0]                                    issue_rd_i,
  input  fu_t                                           issue_fu_i,
  output logic [TRANS_ID_BITS-1:0]                      issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                        wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]     wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]              wb_result_i,
  input  logic [NR_WB_PORTS-1:0]                        wb_ex_valid_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]              wb_ex_cause_i,
  output logic [NR_COMMIT_PORTS-1:0]                    commit_valid_o,
  output logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]          commit_pc_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]               commit_rd_o,
  output fu_t                                           commit_fu_o [NR_COMMIT_PORTS],
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]          commit_result_o,
  output logic [NR_COMMIT_PORTS-1:0]                    commit_ex_valid_o,
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]          commit_ex_cause_o,
  input  logic [NR_COMMIT_PORTS-1:0]                    commit_ack_i
);

  localparam int unsigned CNT_W = $clog2(NR_ENTRIES + 1);
  localparam int unsigned RET_W = $clog2(NR_COMMIT_PORTS + 1);

  rob_entry_t               mem [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] head_q;
  logic [TRANS_ID_BITS-1:0] tail_q;
  logic [CNT_W-1:0]         count_q;
  logic [TRANS_ID_BITS-1:0] commit_idx [NR_COMMIT_PORTS];
  logic [RET_W-1:0]         retire_cnt;
  logic                     issue_fire;

  // No retire-to-allocate bypass: readiness depends on registered occupancy only.
  assign issue_ready_o    = (count_q < CNT_W'(NR_ENTRIES));
  assign issue_trans_id_o = tail_q;
  assign issue_fire       = issue_valid_i & issue_ready_o;

  // Present the head window; an exception entry terminates the valid prefix.
  always_comb begin : commit_present
    logic chain_ok;
    chain_ok = 1'b1;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      commit_idx[i]        = head_q + TRANS_ID_BITS'(i);
      commit_valid_o[i]    = chain_ok & mem[commit_idx[i]].allocated & mem[commit_idx[i]].written;
      chain_ok             = commit_valid_o[i] & ~mem[commit_idx[i]].ex_valid;
      commit_pc_o[i]       = mem[commit_idx[i]].pc;
      commit_rd_o[i]       = mem[commit_idx[i]].rd;
      commit_fu_o[i]       = mem[commit_idx[i]].fu;
      commit_result_o[i]   = mem[commit_idx[i]].result;
      commit_ex_valid_o[i] = mem[commit_idx[i]].ex_valid;
      commit_ex_cause_o[i] = mem[commit_idx[i]].ex_cause;
    end
  end

  // Retire count is the run of leading ones in ack & valid.
  always_comb begin : retire_count
    logic run;
    run        = 1'b1;
    retire_cnt = '0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      run = run & commit_ack_i[i] & commit_valid_o[i];
      if (run) retire_cnt = retire_cnt + RET_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin : rob_state
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < int'(NR_ENTRIES); e++) begin
        mem[e].allocated <= 1'b0;
        mem[e].written   <= 1'b0;
      end
    end else begin
      // Descending loop so the lowest port index is the last assignment and wins.
      for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && mem[wb_trans_id_i[p]].allocated) begin
          mem[wb_trans_id_i[p]].written  <= 1'b1;
          mem[wb_trans_id_i[p]].result   <= wb_result_i[p];
          mem[wb_trans_id_i[p]].ex_valid <= wb_ex_valid_i[p];
          mem[wb_trans_id_i[p]].ex_cause <= wb_ex_cause_i[p];
        end
      end
      for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
        if (RET_W'(i) < retire_cnt) begin
          mem[commit_idx[i]].allocated <= 1'b0;
          mem[commit_idx[i]].written   <= 1'b0;
        end
      end
      // The tail slot is free whenever issue fires, so it never collides with a retiring slot.
      if (issue_fire) begin
        mem[tail_q].allocated <= 1'b1;
        mem[tail_q].written   <= 1'b0;
        mem[tail_q].pc        <= issue_pc_i;
        mem[tail_q].rd        <= issue_rd_i;
        mem[tail_q].fu        <= issue_fu_i;
      end
      head_q  <= head_q + TRANS_ID_BITS'(retire_cnt);
      tail_q  <= tail_q + TRANS_ID_BITS'(issue_fire);
      count_q <= count_q + CNT_W'(issue_fire) - CNT_W'(retire_cnt);
    end
  end

endmodule

// File: tb/tb_commit_rob.sv
// Bench for commit_rob: directed scenarios plus random traffic against a queue-based ROB model.
module tb_commit_rob;
  import ariane_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             issue_valid = 1'b0;
  logic             issue_ready;
  logic [63:0]      issue_pc = '0;
  logic [4:0]       issue_rd = '0;
  fu_t              issue_fu = FU_NONE;
  logic [2:0]       issue_trans_id;
  logic [1:0]       wb_valid = '0;
  logic [1:0][2:0]  wb_trans_id = '0;
  logic [1:0][63:0] wb_result = '0;
  logic [1:0]       wb_ex_valid = '0;
  logic [1:0][63:0] wb_ex_cause = '0;
  logic [1:0]       commit_valid;
  logic [1:0][63:0] commit_pc;
  logic [1:0][4:0]  commit_rd;
  fu_t              commit_fu [2];
  logic [1:0][63:0] commit_result;
  logic [1:0]       commit_ex_valid;
  logic [1:0][63:0] commit_ex_cause;
  logic [1:0]       commit_ack = '0;

  int checks = 0;
  int passes = 0;

  // Model: program-order queue of ids plus per-id contents.
  int          q[$];
  int          next_id = 0;
  bit          m_alloc [8];
  bit          m_written [8];
  logic [63:0] m_pc [8];
  logic [4:0]  m_rd [8];
  fu_t         m_fu [8];
  logic [63:0] m_res [8];
  bit          m_ex [8];
  logic [63:0] m_cause [8];

  always #5 clk = ~clk;

  commit_rob dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_pc_i(issue_pc), .issue_rd_i(issue_rd), .issue_fu_i(issue_fu),
    .issue_trans_id_o(issue_trans_id),
    .wb_valid_i(wb_valid), .wb_trans_id_i(wb_trans_id), .wb_result_i(wb_result),
    .wb_ex_valid_i(wb_ex_valid), .wb_ex_cause_i(wb_ex_cause),
    .commit_valid_o(commit_valid), .commit_pc_o(commit_pc), .commit_rd_o(commit_rd),
    .commit_fu_o(commit_fu), .commit_result_o(commit_result),
    .commit_ex_valid_o(commit_ex_valid), .commit_ex_cause_o(commit_ex_cause),
    .commit_ack_i(commit_ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  function automatic logic [1:0] exp_valid();
    logic [1:0] v;
    bit ok;
    v  = '0;
    ok = 1;
    for (int i = 0; i < 2; i++) begin
      if (ok && i < q.size() && m_written[q[i]]) begin
        v[i] = 1'b1;
        ok   = !m_ex[q[i]];
      end else begin
        ok = 0;
      end
    end
    return v;
  endfunction

  task automatic check_outputs();
    logic [1:0] v;
    v = exp_valid();
    chk("issue_ready", 64'(issue_ready), 64'(q.size() < 8));
    chk("issue_trans_id", 64'(issue_trans_id), 64'(next_id));
    chk("commit_valid", 64'(commit_valid), 64'(v));
    for (int i = 0; i < 2; i++) begin
      if (v[i]) begin
        chk("commit_pc", commit_pc[i], m_pc[q[i]]);
        chk("commit_rd", 64'(commit_rd[i]), 64'(m_rd[q[i]]));
        chk("commit_fu", 64'(commit_fu[i]), 64'(m_fu[q[i]]));
        chk("commit_result", commit_result[i], m_res[q[i]]);
        chk("commit_ex_valid", 64'(commit_ex_valid[i]), 64'(m_ex[q[i]]));
        if (m_ex[q[i]]) chk("commit_ex_cause", commit_ex_cause[i], m_cause[q[i]]);
      end
    end
  endtask

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_edge();
    logic [1:0] v;
    bit run, ready;
    bit taken [8];
    int rc, id;
    if (rst || flush) begin
      q.delete();
      next_id = 0;
      for (int e = 0; e < 8; e++) begin m_alloc[e] = 0; m_written[e] = 0; end
      return;
    end
    v     = exp_valid();
    ready = q.size() < 8;
    rc    = 0;
    run   = 1;
    for (int i = 0; i < 2; i++) begin
      run = run && commit_ack[i] && v[i];
      if (run) rc++;
    end
    for (int e = 0; e < 8; e++) taken[e] = 0;
    for (int p = 0; p < 2; p++) begin
      id = int'(wb_trans_id[p]);
      if (wb_valid[p] && m_alloc[id] && !taken[id]) begin
        taken[id]     = 1;
        m_written[id] = 1;
        m_res[id]     = wb_result[p];
        m_ex[id]      = wb_ex_valid[p];
        m_cause[id]   = wb_ex_cause[p];
      end
    end
    for (int r = 0; r < rc; r++) begin
      id = q.pop_front();
      m_alloc[id] = 0;
      m_written[id] = 0;
    end
    if (issue_valid && ready) begin
      m_alloc[next_id]   = 1;
      m_written[next_id] = 0;
      m_pc[next_id]      = issue_pc;
      m_rd[next_id]      = issue_rd;
      m_fu[next_id]      = issue_fu;
      q.push_back(next_id);
      next_id = (next_id + 1) % 8;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; issue_valid = 0; wb_valid = '0; wb_ex_valid = '0; commit_ack = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic issue_one(input logic [63:0] pc);
    issue_valid = 1; issue_pc = pc; issue_rd = 5'(pc[6:2]); issue_fu = FU_ALU;
    cycle();
    issue_valid = 0;
  endtask

  task automatic set_wb(input int p, input int id, input logic [63:0] res, input bit ex,
                        input logic [63:0] cause);
    wb_valid[p] = 1; wb_trans_id[p] = 3'(id); wb_result[p] = res;
    wb_ex_valid[p] = ex; wb_ex_cause[p] = cause;
  endtask

  initial begin
    @(negedge clk);
    // Reset values
    do_reset();
    chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_trans_id", 64'(issue_trans_id), 64'd0);
    chk("rst_valid", 64'(commit_valid), 64'd0);

    // Out-of-order writeback, in-order commit
    commit_ack = 2'b11;
    issue_one(64'h100); issue_one(64'h104); issue_one(64'h108);
    chk("s1_none", 64'(commit_valid), 64'd0);
    set_wb(0, 1, 64'hA1, 0, '0); cycle(); wb_valid = '0;
    chk("s1_id1_only", 64'(commit_valid), 64'd0);
    set_wb(1, 0, 64'hA0, 0, '0); cycle(); wb_valid = '0;
    chk("s1_pair", 64'(commit_valid), 64'b11);
    chk("s1_pc0", commit_pc[0], 64'h100);
    chk("s1_pc1", commit_pc[1], 64'h104);
    cycle();
    chk("s1_wait2", 64'(commit_valid), 64'd0);
    set_wb(0, 2, 64'hA2, 0, '0); cycle(); wb_valid = '0;
    chk("s1_id2", 64'(commit_valid), 64'b01);
    chk("s1_pc2", commit_pc[0], 64'h108);
    cycle();

    // Full ROB and wrap of the tail
    do_reset();
    for (int i = 0; i < 8; i++) issue_one(64'h200 + 64'(4 * i));
    chk("s2_full_ready", 64'(issue_ready), 64'd0);
    chk("s2_model_count", 64'(q.size()), 64'd8);
    issue_one(64'h2FC);
    chk("s2_still_full", 64'(issue_ready), 64'd0);
    set_wb(0, 0, 64'hB0, 0, '0); set_wb(1, 1, 64'hB1, 0, '0); cycle(); wb_valid = '0;
    commit_ack = 2'b11; cycle(); commit_ack = '0;
    chk("s2_ready_after", 64'(issue_ready), 64'd1);
    chk("s2_wrap_id", 64'(issue_trans_id), 64'd0);

    // Exception entry truncates the commit window
    do_reset();
    issue_one(64'h300); issue_one(64'h304);
    set_wb(0, 0, 64'hC0, 1, 64'd5); set_wb(1, 1, 64'hC1, 0, '0); cycle(); wb_valid = '0;
    chk("s3_valid", 64'(commit_valid), 64'b01);
    chk("s3_ex", 64'(commit_ex_valid[0]), 64'd1);

    // Non-prefix ack is ignored
    do_reset();
    issue_one(64'h400); issue_one(64'h404);
    set_wb(0, 0, 64'hD0, 0, '0); set_wb(1, 1, 64'hD1, 0, '0); cycle(); wb_valid = '0;
    commit_ack = 2'b10; cycle(); commit_ack = '0;
    chk("s4_valid", 64'(commit_valid), 64'b11);
    chk("s4_head", commit_pc[0], 64'h400);

    // Flush beats issue and writeback
    flush = 1; issue_valid = 1; issue_pc = 64'h500; set_wb(0, 1, 64'hE1, 0, '0);
    cycle();
    idle_inputs();
    chk("s5_ready", 64'(issue_ready), 64'd1);
    chk("s5_valid", 64'(commit_valid), 64'd0);
    chk("s5_trans_id", 64'(issue_trans_id), 64'd0);

    // Reset mid-flight
    do_reset();
    for (int i = 0; i < 5; i++) issue_one(64'h600 + 64'(4 * i));
    set_wb(0, 0, 64'hF0, 0, '0); set_wb(1, 1, 64'hF1, 0, '0); cycle(); wb_valid = '0;
    rst = 1; set_wb(0, 2, 64'hF2, 0, '0); cycle(); idle_inputs();
    chk("s6_ready", 64'(issue_ready), 64'd1);
    chk("s6_trans_id", 64'(issue_trans_id), 64'd0);
    chk("s6_valid", 64'(commit_valid), 64'd0);
    set_wb(0, 3, 64'hF3, 0, '0); cycle(); wb_valid = '0;
    chk("s6_wb_ignored", 64'(commit_valid), 64'd0);
    issue_one(64'h700);
    chk("s6_fresh", 64'(commit_valid), 64'd0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      flush       = ($urandom_range(0, 79) == 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_pc    = {$urandom, $urandom};
      issue_rd    = 5'($urandom_range(0, 31));
      issue_fu    = fu_t'(4'($urandom_range(0, 7)));
      for (int p = 0; p < 2; p++) begin
        wb_valid[p]    = ($urandom_range(0, 1) == 1);
        wb_trans_id[p] = 3'($urandom_range(0, 7));
        wb_result[p]   = {$urandom, $urandom};
        wb_ex_valid[p] = ($urandom_range(0, 7) == 0);
        wb_ex_cause[p] = 64'($urandom);
      end
      commit_ack = 2'($urandom_range(0, 3));
      cycle();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
